// File: rtl/spi_sampler_pkg.sv
// Shared definitions for the SPI sampler slave: mode encoding, CPOL/CPHA
// field positions and default parameter values.
package spi_sampler_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } spi_mode_e;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_CHANNELS   = 4;
  localparam int unsigned DEF_FILTER_LEN = 2;
  localparam int unsigned DEF_MODE       = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  function automatic logic mode_cpol(input int unsigned mode);
    logic [1:0] m;
    m = 2'(mode);
    return m[CPOL_BIT];
  endfunction

  function automatic logic mode_cpha(input int unsigned mode);
    logic [1:0] m;
    m = 2'(mode);
    return m[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_glitch_filter.sv
// 2-flop synchronizer plus glitch filter: output follows the input only after
// FILTER_LEN consecutive equal synchronized samples.
module spi_glitch_filter #(
  parameter int unsigned FILTER_LEN = 2,
  parameter logic        IDLE       = 1'b1
) (
  input  logic CLK,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  q_q;
  logic                  q_d;

  always_comb begin
    q_d = q_q;
    if (&hist_q) begin
      q_d = 1'b1;
    end else if (~|hist_q) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync_q <= {2{IDLE}};
      hist_q <= {FILTER_LEN{IDLE}};
      q_q    <= IDLE;
    end else begin
      sync_q <= {sync_q[0], d_i};
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      q_q    <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spi_sampler_slave.sv
// SPI slave that receives words on mosi and streams a per-frame snapshot of
// parallel pin_values back on miso, one WIDTH-bit channel per word.
module spi_sampler_slave
  import spi_sampler_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned MODE       = DEF_MODE
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      spi_clk,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  input  logic [CHANNELS*WIDTH-1:0] pin_values,
  output logic [WIDTH-1:0]          rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_active,
  output logic                      overrun
);

  localparam logic        CPOL = mode_cpol(MODE);
  localparam logic        CPHA = mode_cpha(MODE);
  localparam int unsigned BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic sclk_f, cs_f;

  spi_glitch_filter #(.FILTER_LEN(FILTER_LEN), .IDLE(CPOL)) u_sclk_filt (
    .CLK(CLK), .reset(reset), .d_i(spi_clk), .q_o(sclk_f)
  );

  spi_glitch_filter #(.FILTER_LEN(FILTER_LEN), .IDLE(1'b1)) u_cs_filt (
    .CLK(CLK), .reset(reset), .d_i(cs_n), .q_o(cs_f)
  );

  frame_state_e           state_q, state_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic [1:0]             mosi_sync_q;
  logic [FILTER_LEN:0]    mosi_dly_q;
  logic [WIDTH-1:0]       bank_q [CHANNELS];
  logic [CH_W-1:0]        ch_idx_q, ch_idx_d, ch_next;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_sr_q, rx_sr_d, rx_shift;
  logic [WIDTH-1:0]       tx_q, tx_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   miso_q, miso_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_active_q, frame_active_d;
  logic                   load_bank;
  logic                   mosi_al, cs_fall, sclk_edge, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge;

  // mosi delayed by the same depth as the filter so it lines up with sclk_f
  assign mosi_al     = mosi_dly_q[FILTER_LEN];
  assign cs_fall     = cs_prev_q && !cs_f;
  assign sclk_edge   = sclk_f ^ sclk_prev_q;
  assign lead_edge   = sclk_edge && (sclk_f != CPOL);
  assign trail_edge  = sclk_edge && (sclk_f == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign rx_shift    = WIDTH'({rx_sr_q, mosi_al});
  assign ch_next     = (ch_idx_q == CH_W'(CHANNELS - 1)) ? '0 : ch_idx_q + CH_W'(1);

  always_comb begin
    state_d        = state_q;
    ch_idx_d       = ch_idx_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_d           = tx_q;
    miso_d         = miso_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    overrun_d      = overrun_q;
    frame_active_d = frame_active_q;
    load_bank      = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d         = 1'b0;
        bit_cnt_d      = '0;
        frame_active_d = 1'b0;
        if (cs_fall) begin
          state_d        = ST_ACTIVE;
          frame_active_d = 1'b1;
          load_bank      = 1'b1;
          ch_idx_d       = '0;
          // CPHA=0 must drive the MSB before the first clock edge arrives
          if (CPHA) begin
            tx_d = pin_values[WIDTH-1:0];
          end else begin
            miso_d = pin_values[WIDTH-1];
            tx_d   = pin_values[WIDTH-1:0] << 1;
          end
        end
      end
      ST_ACTIVE: begin
        if (cs_f) begin
          state_d        = ST_IDLE;
          frame_active_d = 1'b0;
          miso_d         = 1'b0;
          bit_cnt_d      = '0;
        end else begin
          if (shift_edge) begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = tx_q << 1;
          end
          if (sample_edge) begin
            rx_sr_d = rx_shift;
            if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
              bit_cnt_d  = '0;
              ch_idx_d   = ch_next;
              tx_d       = bank_q[ch_next];
              rx_data_d  = rx_shift;
              rx_valid_d = 1'b1;
              if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sclk_prev_q    <= CPOL;
      cs_prev_q      <= 1'b1;
      mosi_sync_q    <= '0;
      mosi_dly_q     <= '0;
      ch_idx_q       <= '0;
      bit_cnt_q      <= '0;
      rx_sr_q        <= '0;
      tx_q           <= '0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      overrun_q      <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sclk_prev_q    <= sclk_f;
      cs_prev_q      <= cs_f;
      mosi_sync_q    <= {mosi_sync_q[0], mosi};
      mosi_dly_q     <= {mosi_dly_q[FILTER_LEN-1:0], mosi_sync_q[1]};
      ch_idx_q       <= ch_idx_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_sr_q        <= rx_sr_d;
      tx_q           <= tx_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      overrun_q      <= overrun_d;
      frame_active_q <= frame_active_d;
    end
  end

  // Per-frame snapshot of the parallel inputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) bank_q[k] <= '0;
    end else if (load_bank) begin
      for (int k = 0; k < CHANNELS; k++) bank_q[k] <= pin_values[k*WIDTH +: WIDTH];
    end
  end

  assign miso         = miso_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign overrun      = overrun_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_spi_sampler_slave.sv
// Directed bench: instance A is MODE 0 / FILTER_LEN 2, instance B is MODE 3 /
// FILTER_LEN 3; a bit-banged SPI master drives each.
module tb_spi_sampler_slave;

  localparam int H = 10;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  sclk, csn, mosi;
  logic        rx_ready;
  logic [31:0] pins;
  logic        miso_a, miso_b, rv_a, rv_b, fa_a, fa_b, ovr_a, ovr_b;
  logic [7:0]  rxd_a, rxd_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rv_cnt [2] = '{0, 0};
  logic [7:0]  rv_last [2];

  always #5 CLK = ~CLK;

  spi_sampler_slave u_a (
    .CLK(CLK), .reset(reset), .spi_clk(sclk[0]), .cs_n(csn[0]), .mosi(mosi[0]),
    .miso(miso_a), .pin_values(pins), .rx_data(rxd_a), .rx_valid(rv_a),
    .rx_ready(rx_ready), .frame_active(fa_a), .overrun(ovr_a)
  );

  spi_sampler_slave #(.MODE(3), .FILTER_LEN(3)) u_b (
    .CLK(CLK), .reset(reset), .spi_clk(sclk[1]), .cs_n(csn[1]), .mosi(mosi[1]),
    .miso(miso_b), .pin_values(pins), .rx_data(rxd_b), .rx_valid(rv_b),
    .rx_ready(rx_ready), .frame_active(fa_b), .overrun(ovr_b)
  );

  always @(negedge CLK) begin
    if (rv_a) begin rv_cnt[0]++; rv_last[0] = rxd_a; end
    if (rv_b) begin rv_cnt[1]++; rv_last[1] = rxd_b; end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic frame_start(input int s);
    csn[s] = 1'b0;
    wait_clk(2*H);
  endtask

  task automatic frame_end(input int s);
    wait_clk(H);
    csn[s] = 1'b1;
    wait_clk(2*H);
  endtask

  // Instance 0 is CPOL=0/CPHA=0, instance 1 is CPOL=1/CPHA=1
  task automatic send_bits(input int s, input logic [7:0] d, input int nbits,
                           output logic [7:0] got);
    logic cpol;
    cpol = (s == 1);
    got  = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (s == 0) begin
        mosi[s] = d[i];
        wait_clk(H);
        sclk[s] = ~cpol;
        got[i]  = miso_a;
        wait_clk(H);
        sclk[s] = cpol;
      end else begin
        wait_clk(H);
        sclk[s] = ~cpol;
        mosi[s] = d[i];
        wait_clk(H);
        sclk[s] = cpol;
        got[i]  = miso_b;
      end
    end
    wait_clk(H);
  endtask

  task automatic test_reset;
    reset = 1'b1; sclk = 2'b10; csn = 2'b11; mosi = 2'b00; rx_ready = 1'b1; pins = '0;
    wait_clk(3);
    n_cmp++; if (miso_a !== 1'b0) begin n_bad++; $display("FAIL rst_miso_a got %b want 0", miso_a); end
    n_cmp++; if (rxd_a !== 8'h00) begin n_bad++; $display("FAIL rst_rxd_a got %h want 00", rxd_a); end
    n_cmp++; if (rv_a !== 1'b0) begin n_bad++; $display("FAIL rst_rv_a got %b want 0", rv_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL rst_ovr_a got %b want 0", ovr_a); end
    n_cmp++; if (fa_a !== 1'b0) begin n_bad++; $display("FAIL rst_fa_a got %b want 0", fa_a); end
    n_cmp++; if (miso_b !== 1'b0) begin n_bad++; $display("FAIL rst_miso_b got %b want 0", miso_b); end
    n_cmp++; if (rxd_b !== 8'h00) begin n_bad++; $display("FAIL rst_rxd_b got %h want 00", rxd_b); end
    n_cmp++; if (rv_b !== 1'b0) begin n_bad++; $display("FAIL rst_rv_b got %b want 0", rv_b); end
    n_cmp++; if (ovr_b !== 1'b0) begin n_bad++; $display("FAIL rst_ovr_b got %b want 0", ovr_b); end
    n_cmp++; if (fa_b !== 1'b0) begin n_bad++; $display("FAIL rst_fa_b got %b want 0", fa_b); end
    reset = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_mode0_basic;
    logic [7:0] got;
    int base;
    pins = 32'h0000_003C;
    base = rv_cnt[0];
    frame_start(0);
    n_cmp++; if (fa_a !== 1'b1) begin n_bad++; $display("FAIL m0_frame_active got %b want 1", fa_a); end
    send_bits(0, 8'hA5, 8, got);
    n_cmp++; if (got !== 8'h3C) begin n_bad++; $display("FAIL m0_miso got %h want 3c", got); end
    n_cmp++; if (rv_cnt[0] - base !== 1) begin n_bad++; $display("FAIL m0_rv_pulses got %0d want 1", rv_cnt[0] - base); end
    n_cmp++; if (rv_last[0] !== 8'hA5) begin n_bad++; $display("FAIL m0_rx_data got %h want a5", rv_last[0]); end
    frame_end(0);
    n_cmp++; if (fa_a !== 1'b0) begin n_bad++; $display("FAIL m0_fa_after got %b want 0", fa_a); end
    n_cmp++; if (miso_a !== 1'b0) begin n_bad++; $display("FAIL m0_miso_idle got %b want 0", miso_a); end
  endtask

  task automatic test_mode3_wrap;
    logic [7:0] got;
    logic [7:0] exp_miso [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int base;
    pins = 32'h4433_2211;
    base = rv_cnt[1];
    frame_start(1);
    for (int w = 0; w < 5; w++) begin
      send_bits(1, 8'(8'h10 + w), 8, got);
      if (w == 0) pins = 32'hDEAD_BEEF;
      n_cmp++; if (got !== exp_miso[w]) begin n_bad++; $display("FAIL m3_miso_w%0d got %h want %h", w, got, exp_miso[w]); end
    end
    n_cmp++; if (rv_cnt[1] - base !== 5) begin n_bad++; $display("FAIL m3_rv_pulses got %0d want 5", rv_cnt[1] - base); end
    n_cmp++; if (rv_last[1] !== 8'h14) begin n_bad++; $display("FAIL m3_rx_data got %h want 14", rv_last[1]); end
    frame_end(1);
    n_cmp++; if (miso_b !== 1'b0) begin n_bad++; $display("FAIL m3_miso_idle got %b want 0", miso_b); end
  endtask

  task automatic test_overrun;
    logic [7:0] got;
    rx_ready = 1'b0;
    frame_start(0);
    send_bits(0, 8'h01, 8, got);
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL ovr_rv_w1 got %b want 1", rv_a); end
    n_cmp++; if (rxd_a !== 8'h01) begin n_bad++; $display("FAIL ovr_rxd_w1 got %h want 01", rxd_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL ovr_flag_w1 got %b want 0", ovr_a); end
    send_bits(0, 8'h02, 8, got);
    frame_end(0);
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL ovr_rv_w2 got %b want 1", rv_a); end
    n_cmp++; if (rxd_a !== 8'h02) begin n_bad++; $display("FAIL ovr_rxd_w2 got %h want 02", rxd_a); end
    n_cmp++; if (ovr_a !== 1'b1) begin n_bad++; $display("FAIL ovr_flag_w2 got %b want 1", ovr_a); end
    rx_ready = 1'b1;
    wait_clk(2);
    n_cmp++; if (rv_a !== 1'b0) begin n_bad++; $display("FAIL ovr_rv_accept got %b want 0", rv_a); end
    n_cmp++; if (ovr_a !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", ovr_a); end
  endtask

  task automatic test_glitch;
    logic [7:0] got;
    int base;
    pins = 32'h0000_0096;
    base = rv_cnt[1];
    frame_start(1);
    for (int g = 0; g < 3; g++) begin
      sclk[1] = 1'b0;
      wait_clk(1);
      sclk[1] = 1'b1;
      wait_clk(8);
    end
    n_cmp++; if (rv_cnt[1] - base !== 0) begin n_bad++; $display("FAIL glitch_no_rv got %0d want 0", rv_cnt[1] - base); end
    n_cmp++; if (miso_b !== 1'b0) begin n_bad++; $display("FAIL glitch_miso got %b want 0", miso_b); end
    send_bits(1, 8'h5A, 8, got);
    n_cmp++; if (got !== 8'h96) begin n_bad++; $display("FAIL glitch_miso_word got %h want 96", got); end
    n_cmp++; if (rv_cnt[1] - base !== 1) begin n_bad++; $display("FAIL glitch_rv_pulses got %0d want 1", rv_cnt[1] - base); end
    n_cmp++; if (rv_last[1] !== 8'h5A) begin n_bad++; $display("FAIL glitch_rx_data got %h want 5a", rv_last[1]); end
    frame_end(1);
  endtask

  task automatic test_abort;
    logic [7:0] got;
    int base;
    pins = 32'h0000_00C3;
    base = rv_cnt[0];
    frame_start(0);
    send_bits(0, 8'hFF, 5, got);
    frame_end(0);
    n_cmp++; if (rv_cnt[0] - base !== 0) begin n_bad++; $display("FAIL abort_no_rv got %0d want 0", rv_cnt[0] - base); end
    frame_start(0);
    send_bits(0, 8'h81, 8, got);
    frame_end(0);
    n_cmp++; if (rv_cnt[0] - base !== 1) begin n_bad++; $display("FAIL abort_rv_pulses got %0d want 1", rv_cnt[0] - base); end
    n_cmp++; if (rv_last[0] !== 8'h81) begin n_bad++; $display("FAIL abort_rx_data got %h want 81", rv_last[0]); end
    n_cmp++; if (got !== 8'hC3) begin n_bad++; $display("FAIL abort_miso got %h want c3", got); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] got;
    int base;
    pins = 32'h0000_00E7;
    frame_start(0);
    send_bits(0, 8'hFF, 4, got);
    reset = 1'b1;
    wait_clk(1);
    n_cmp++; if (miso_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_miso got %b want 0", miso_a); end
    n_cmp++; if (rxd_a !== 8'h00) begin n_bad++; $display("FAIL rstmid_rxd got %h want 00", rxd_a); end
    n_cmp++; if (rv_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_rv got %b want 0", rv_a); end
    n_cmp++; if (ovr_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovr got %b want 0", ovr_a); end
    n_cmp++; if (fa_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_fa got %b want 0", fa_a); end
    wait_clk(1);
    reset = 1'b0;
    csn[0] = 1'b1;
    wait_clk(2*H);
    base = rv_cnt[0];
    frame_start(0);
    send_bits(0, 8'h3E, 8, got);
    frame_end(0);
    n_cmp++; if (got !== 8'hE7) begin n_bad++; $display("FAIL rstmid_miso_word got %h want e7", got); end
    n_cmp++; if (rv_cnt[0] - base !== 1) begin n_bad++; $display("FAIL rstmid_rv_pulses got %0d want 1", rv_cnt[0] - base); end
    n_cmp++; if (rv_last[0] !== 8'h3E) begin n_bad++; $display("FAIL rstmid_rx_data got %h want 3e", rv_last[0]); end
  endtask

  initial begin
    test_reset;
    test_mode0_basic;
    test_mode3_wrap;
    test_overrun;
    test_glitch;
    test_abort;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_sampler_slave.md
SPI_SAMPLER_SLAVE -- requirements
Module: spi_sampler_slave

Interface
REQ-001 Clock and reset SHALL be: reset reset, synchronous, active-high; clock CLK.
REQ-002 Parameter WIDTH, 8, bits per SPI word and per channel.
REQ-003 Parameter CHANNELS, 4, number of WIDTH-bit sample channels; legal range 1..16.
REQ-004 Parameter FILTER_LEN, 2, consecutive equal samples required to change a filtered input; legal range 2..8.
REQ-005 Parameter MODE, 0, SPI mode 0..3; bit 1 is CPOL, bit 0 is CPHA.
REQ-006 CLK  input  1  system clock; spi_clk frequency SHALL be at most CLK/(2*(FILTER_LEN+2)).
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 spi_clk  input  1  asynchronous SPI SCLK.
REQ-009 cs_n  input  1  asynchronous SPI chip select, active-low.
REQ-010 mosi  input  1  asynchronous SPI data in.
REQ-011 miso  output  1  SPI data out, MSB first.
REQ-012 pin_values  input  CHANNELS*WIDTH  parallel sample inputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 rx_data  output  WIDTH  last received word.
REQ-014 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-015 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-016 frame_active  output  1  filtered cs_n is low.
REQ-017 overrun  output  1  sticky; a word completed while rx_valid was high.

Function
REQ-018 spi_clk and cs_n SHALL each pass a 2-flop synchronizer followed by a glitch filter; the filtered output changes only after FILTER_LEN consecutive equal synchronized samples and otherwise holds.
REQ-019 mosi SHALL be synchronized and delayed so that it is aligned with the filtered spi_clk.
REQ-020 Leading edge = idle-to-active transition of filtered SCLK (idle level = CPOL); trailing edge = the opposite transition.
REQ-021 Sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other edge.
REQ-022 On a filtered cs_n falling edge: pin_values snapshotted into a bank register; channel index = 0; bit counter = 0; tx shift register loaded with channel 0.
REQ-023 CPHA=0: miso SHALL present the MSB of the loaded word from the cycle after the cs_n fall and advance one bit on each shift edge.
REQ-024 CPHA=1: miso SHALL present the next bit, starting with the MSB, on each shift edge.
REQ-025 Each sample edge SHALL shift the aligned mosi into the rx shift register, LSB end, and increment the bit counter.
REQ-026 When the sample edge for bit WIDTH-1 is detected: rx_data is loaded and rx_valid is set in the next cycle; the bit counter wraps to 0; the channel index increments modulo CHANNELS; tx is reloaded from the snapshot bank at the new index.
REQ-027 rx_valid SHALL clear in the cycle after rx_valid&&rx_ready and otherwise hold.
REQ-028 A word completing while rx_valid=1 and rx_ready=0 SHALL overwrite rx_data, keep rx_valid=1, and set overrun; a completion coinciding with acceptance SHALL NOT set overrun.
REQ-029 overrun SHALL clear only on reset.
REQ-030 A filtered cs_n rise mid-word SHALL discard the partial word: no rx_valid, bit counter = 0.
REQ-031 SCLK edges while cs_n is high SHALL be ignored.
REQ-032 miso SHALL be 0 while frame_active=0.
REQ-033 The pin_values snapshot SHALL be taken once per frame; changes during a frame SHALL NOT affect miso.

Reset
REQ-034 While reset is high: miso=0, rx_data=0, rx_valid=0, overrun=0, frame_active=0, filters preset to their idle levels (SCLK=CPOL, cs_n=1), all counters 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame; a new frame SHALL begin only after a filtered cs_n falling edge that follows reset release.

Structure
REQ-036 Shared package spi_sampler_pkg SHALL hold the MODE encoding constants, the CPOL/CPHA field positions and the default parameter values.
REQ-037 Sub-module spi_glitch_filter (parameter FILTER_LEN, IDLE) SHALL implement REQ-018 and be instantiated for spi_clk and cs_n.

Verification
REQ-038 MODE=0, WIDTH=8: master sends 0xA5 -> rx_data=0xA5, rx_valid pulses; with pin_values ch0=0x3C, miso returns 0x3C.
REQ-039 MODE=3, CHANNELS=4, pins=0x44332211, 4-word frame -> miso returns 0x11,0x22,0x33,0x44; a 5th word returns 0x11 (wrap).
REQ-040 rx_ready held 0 across two words 0x01,0x02 -> rx_data=0x02, overrun=1; then rx_ready=1 -> rx_valid=0, overrun stays 1.
REQ-041 1-CLK glitch pulses on spi_clk, FILTER_LEN=3, cs_n low -> bit counter unchanged, no rx_valid.
REQ-042 cs_n raised after 5 bits, then a new frame sends 0x81 -> single rx_valid with rx_data=0x81.
REQ-043 reset pulsed after 4 bits of a frame -> all outputs at reset values; the next full frame is received correctly.
